// File: rtl/exu_alu_pipe.sv
// Execute-stage integer ALU with one registered result stage, a valid/ready handshake,
// flush, and destination tag passthrough. Supports RV64 word-mode (*W) operations.
package exu_alu_pkg;
    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLT  = 4'd5,
        ALU_SLTU = 4'd6,
        ALU_SLL  = 4'd7,
        ALU_SRL  = 4'd8,
        ALU_SRA  = 4'd9
    } alu_op_t;
endpackage

module exu_alu_pipe
    import exu_alu_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int TAG_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  alu_op_t          in_alu_op_i,
    input  logic             in_word_i,
    input  logic [XLEN-1:0]  in_operandA_i,
    input  logic [XLEN-1:0]  in_operandB_i,
    input  logic [TAG_W-1:0] in_tag_i,
    input  logic             flush_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [XLEN-1:0]  out_result_o,
    output logic [TAG_W-1:0] out_tag_o
);
    localparam int SHW = $clog2(XLEN);

    logic            needSub;
    logic [XLEN-1:0] opB;
    logic [XLEN:0]   addFull;
    logic [XLEN-1:0] sum;
    logic            carryOut;
    logic            sltBit;
    logic            sltuBit;
    logic [SHW-1:0]  shamt;
    logic [XLEN-1:0] sllRes;
    logic [XLEN-1:0] srlRes;
    logic [XLEN-1:0] sraRes;
    logic            wordMode;
    logic [XLEN-1:0] wordRes;
    logic [XLEN-1:0] aluResult;

    // One shared adder serves ADD/SUB and both compares; the carry-out gives SLTU.
    assign needSub  = (in_alu_op_i == ALU_SUB) || (in_alu_op_i == ALU_SLT) ||
                      (in_alu_op_i == ALU_SLTU);
    assign opB      = needSub ? ~in_operandB_i : in_operandB_i;
    assign addFull  = {1'b0, in_operandA_i} + {1'b0, opB} + {{XLEN{1'b0}}, needSub};
    assign sum      = addFull[XLEN-1:0];
    assign carryOut = addFull[XLEN];
    assign sltBit   = (in_operandA_i[XLEN-1] & ~in_operandB_i[XLEN-1]) |
                      (~(in_operandA_i[XLEN-1] ^ in_operandB_i[XLEN-1]) & sum[XLEN-1]);
    assign sltuBit  = ~carryOut;

    assign shamt  = in_operandB_i[SHW-1:0];
    assign sllRes = in_operandA_i << shamt;
    assign srlRes = in_operandA_i >> shamt;
    assign sraRes = $signed(in_operandA_i) >>> shamt;

    generate
        if (XLEN == 64) begin : gWord
            logic [4:0]  wShamt;
            logic [31:0] wRes;

            assign wShamt = in_operandB_i[4:0];

            // Low 32 bits of the shared adder are exactly the ADDW/SUBW result.
            always_comb begin
                wRes = '0;
                case (in_alu_op_i)
                    ALU_ADD, ALU_SUB: wRes = sum[31:0];
                    ALU_SLL:          wRes = in_operandA_i[31:0] << wShamt;
                    ALU_SRL:          wRes = in_operandA_i[31:0] >> wShamt;
                    ALU_SRA:          wRes = $signed(in_operandA_i[31:0]) >>> wShamt;
                    default:          wRes = '0;
                endcase
            end

            assign wordMode = in_word_i &&
                              ((in_alu_op_i == ALU_ADD) || (in_alu_op_i == ALU_SUB) ||
                               (in_alu_op_i == ALU_SLL) || (in_alu_op_i == ALU_SRL) ||
                               (in_alu_op_i == ALU_SRA));
            assign wordRes  = {{(XLEN-32){wRes[31]}}, wRes};
        end else begin : gNoWord
            assign wordMode = 1'b0;
            assign wordRes  = '0;
        end
    endgenerate

    always_comb begin
        aluResult = '0;
        case (in_alu_op_i)
            ALU_ADD, ALU_SUB: aluResult = sum;
            ALU_AND:          aluResult = in_operandA_i & in_operandB_i;
            ALU_OR:           aluResult = in_operandA_i | in_operandB_i;
            ALU_XOR:          aluResult = in_operandA_i ^ in_operandB_i;
            ALU_SLT:          aluResult = {{(XLEN-1){1'b0}}, sltBit};
            ALU_SLTU:         aluResult = {{(XLEN-1){1'b0}}, sltuBit};
            ALU_SLL:          aluResult = sllRes;
            ALU_SRL:          aluResult = srlRes;
            ALU_SRA:          aluResult = sraRes;
            default:          aluResult = '0;
        endcase
        if (wordMode) begin
            aluResult = wordRes;
        end
    end

    logic             outValid_q;
    logic             outValid_d;
    logic [XLEN-1:0]  outResult_q;
    logic [XLEN-1:0]  outResult_d;
    logic [TAG_W-1:0] outTag_q;
    logic [TAG_W-1:0] outTag_d;
    logic             inFire;
    logic             outFire;

    assign in_ready_o = ~outValid_q | out_ready_i;
    assign inFire     = in_valid_i & in_ready_o & ~flush_i;
    assign outFire    = outValid_q & out_ready_i;

    // Flush suppresses loading (via inFire) and empties the stage at the next edge.
    always_comb begin
        outValid_d  = outValid_q;
        outResult_d = outResult_q;
        outTag_d    = outTag_q;
        if (inFire) begin
            outValid_d  = 1'b1;
            outResult_d = aluResult;
            outTag_d    = in_tag_i;
        end else if (flush_i || outFire) begin
            outValid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outValid_q  <= 1'b0;
            outResult_q <= '0;
            outTag_q    <= '0;
        end else begin
            outValid_q  <= outValid_d;
            outResult_q <= outResult_d;
            outTag_q    <= outTag_d;
        end
    end

    assign out_valid_o  = outValid_q;
    assign out_result_o = outResult_q;
    assign out_tag_o    = outTag_q;

endmodule

// File: doc/exu_alu_pipe.md
# exu_alu_pipe

Parametrised, registered integer ALU for the execute stage. It generalises the combinational single-cycle ALU in three ways: a configurable datapath width, RV64 word-mode (`*W`) operations, and a one-stage result register with a valid/ready handshake, flush and tag passthrough. It sits between issue and writeback. Issue presents one operation per cycle, and the writeback/bypass network consumes the registered result one cycle later.

## Interface
Parameters:
- `XLEN`, default 64: datapath width. Legal values are 32 and 64.
- `TAG_W`, default 6: width of the destination tag that passes through with each operation.

Ports:
- `clk`, in, 1: the single clock. All state updates on the rising edge.
- `rst_n`, in, 1: reset. Asynchronous, active-low.
- `in_valid`, in, 1: an operation is presented.
- `in_ready`, out, 1: the unit can accept an operation this cycle.
- `in_alu_op`, in, `alu_op_t`: the operation, one of ADD, SUB, AND, OR, XOR, SLT, SLTU, SLL, SRL, SRA.
- `in_word`, in, 1: word mode, i.e. a 32-bit operation whose result is sign-extended. Honoured only when XLEN=64.
- `in_operandA`, in, XLEN: operand A.
- `in_operandB`, in, XLEN: operand B.
- `in_tag`, in, TAG_W: destination tag.
- `flush`, in, 1: kills all in-flight and incoming work.
- `out_valid`, out, 1: the result register holds a valid result.
- `out_ready`, in, 1: the consumer accepts the result.
- `out_result`, out, XLEN: the registered result.
- `out_tag`, out, TAG_W: the tag of the registered result.

## Operation
Transfer and acceptance:
- An input transfer happens when `in_valid & in_ready & ~flush`. An output transfer happens when `out_valid & out_ready`.
- `in_ready = ~out_valid | out_ready`. This is combinational from `out_ready`, so full throughput is one operation per cycle.

Adder, compare and shift:
- The adder computes A + (need_sub ? ~B : B) + need_sub, where need_sub = op in {SUB, SLT, SLTU}.
- SLT result = (A[msb] & ~B[msb]) | (~(A[msb]^B[msb]) & sum[msb]).
- SLTU result = ~carry_out. Both compare results are zero-extended to XLEN.
- Shift amount is B[$clog2(XLEN)-1:0]. SRA is arithmetic.

Word mode (XLEN=64, `in_word`=1):
- ADD, SUB, SLL, SRL and SRA operate on A[31:0] and B[31:0].
- Shift amount is B[4:0]. SRLW shifts zero-extended A[31:0]; SRAW shifts sign-extended A[31:0].
- The result is {{32{r[31]}}, r[31:0]}.
- For AND, OR, XOR, SLT and SLTU, `in_word` is ignored and the full-width result is produced.

Other results:
- When XLEN=32, `in_word` is ignored.
- Any op not in the list above produces result 0 and still completes with its tag.

Result register:
- On an input transfer, the register loads the result and tag and sets `out_valid`=1.
- When an output transfer occurs with no input transfer, `out_valid` is cleared.
- On a simultaneous output and input transfer, the register loads the new result and `out_valid` stays 1.

Flush:
- Flush clears `out_valid` at the next edge and blocks any input transfer in the same cycle, even if `in_valid & in_ready`.
- `out_valid`, `out_result` and `out_tag` are combinationally unaffected during the flush cycle; the consumer must qualify with `flush` itself.

Reset:
- Values: `out_valid`=0, `out_result`=0, `out_tag`=0.
- An assertion mid-operation discards the held result immediately and asynchronously.
- The first input transfer is possible in the first cycle after `rst_n` deasserts.

## Timing
- Latency: an operation accepted at edge N is visible on `out_*` after edge N, i.e. in cycle N+1.
- Throughput: one operation per cycle while `out_ready`=1.
- Backpressure: while `out_valid & ~out_ready`, `in_ready`=0, and `out_result` and `out_tag` hold stable.
- The datapath is combinational from the inputs to the register D-input in a single cycle, with no multicycle paths.
- Flush takes effect at the next edge. There is no combinational path from `flush` to the outputs.

## Test plan
- **ADD wrap.** ADD, A=0xFFFF_FFFF_FFFF_FFFF, B=1, tag=5. Next cycle: `out_valid`=1, result 0, `out_tag`=5.
- **Word-mode arithmetic.** ADDW, A=0x7FFF_FFFF, B=1. Result is 0xFFFF_FFFF_8000_0000. SRAW, A=0x8000_0000, B=0x21 (shamt 1). Result is 0xFFFF_FFFF_C000_0000.
- **Compares.** SLT, A=-1, B=1 gives 1. SLTU with the same operands gives 0. SLT, A=0x8000_0000_0000_0000, B=0x7FFF_FFFF_FFFF_FFFF gives 1.
- **Backpressure.** Issue 3 back-to-back ops with `out_ready` held 0 for 2 cycles after the first result. The first result holds stable, `in_ready`=0, and all three results arrive in order with no loss or duplication.
- **Flush.** Assert `flush` while a result is held and a new op is offered. Next cycle `out_valid`=0, the offered op never appears, and the following op completes normally.
- **Reset and XLEN=32.** Assert `rst_n` low asynchronously while `out_valid`=1: outputs go to 0 immediately. With an XLEN=32 instance, SLL with A=1 and B=31 gives 0x8000_0000, and `in_word`=1 changes nothing.
